// File: rtl/usb_out_pkt_fifo.sv
// Packet-aware OUT bulk endpoint buffer: speculative SIE writes are committed on EOP
// or rolled back on error, and packets are NAKed when a full max-size packet cannot fit.
module usb_out_pkt_fifo #(
  parameter int DEPTH             = 64,
  parameter int OUT_MAXPACKETSIZE = 64,
  parameter int DATA_W            = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     clk_gate_i,
  input  logic                     bus_reset_i,
  input  logic [DATA_W-1:0]        out_data_i,
  input  logic                     out_valid_i,
  input  logic                     out_err_i,
  input  logic                     out_ready_i,
  output logic                     out_nak_o,
  output logic [DATA_W-1:0]        app_out_data_o,
  output logic                     app_out_valid_o,
  input  logic                     app_out_ready_i,
  output logic                     out_empty_o,
  output logic                     out_full_o,
  output logic [$clog2(DEPTH):0]   out_level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] MPS_C   = (AW+1)'(OUT_MAXPACKETSIZE);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, wr_tmp, rd_ptr;
  logic [AW:0]       used, free, committed;
  logic              srst, sie_evt, ev_data, ev_err, ev_eop;
  logic              mem_we, rd_en;

  assign srst    = ~rstn_i | bus_reset_i;
  assign sie_evt = clk_gate_i & out_ready_i;
  assign ev_data = sie_evt & out_valid_i;
  assign ev_err  = sie_evt & out_err_i & ~out_valid_i;
  assign ev_eop  = sie_evt & ~out_valid_i & ~out_err_i;

  // free uses the pre-edge rd_ptr, so a concurrent app read only makes admission conservative
  assign used      = wr_tmp - rd_ptr;
  assign free      = DEPTH_C - used;
  assign committed = wr_ptr - rd_ptr;

  assign mem_we = ev_data & (((state == IDLE) & (free >= MPS_C)) |
                             ((state == RECV) & (used != DEPTH_C)));
  assign rd_en  = (~app_out_valid_o | app_out_ready_i) & (rd_ptr != wr_ptr);

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[wr_tmp[AW-1:0]] <= out_data_i;
  end

  // SIE side: speculative write pointer, commit/rollback and NAK decision
  always_ff @(posedge clk_i) begin
    if (srst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      wr_tmp    <= '0;
      out_nak_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ev_data) begin
            if (free >= MPS_C) begin
              wr_tmp    <= wr_tmp + (AW+1)'(1);
              out_nak_o <= 1'b0;
              state     <= RECV;
            end else begin
              out_nak_o <= 1'b1;
              state     <= DROP;
            end
          end else if (ev_eop | ev_err) begin
            out_nak_o <= 1'b0;
          end
        end
        RECV: begin
          if (ev_data) begin
            if (used != DEPTH_C) begin
              wr_tmp <= wr_tmp + (AW+1)'(1);
            end else begin
              wr_tmp    <= wr_ptr;
              out_nak_o <= 1'b1;
              state     <= DROP;
            end
          end else if (ev_eop) begin
            wr_ptr <= wr_tmp;
            state  <= IDLE;
          end else if (ev_err) begin
            wr_tmp <= wr_ptr;
            state  <= IDLE;
          end
        end
        DROP: begin
          if (ev_eop) begin
            state <= IDLE;
          end else if (ev_err) begin
            out_nak_o <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // App side: one-entry output register fed from committed memory only
  always_ff @(posedge clk_i) begin
    if (srst) begin
      rd_ptr          <= '0;
      app_out_valid_o <= 1'b0;
      app_out_data_o  <= '0;
    end else if (rd_en) begin
      app_out_data_o  <= mem[rd_ptr[AW-1:0]];
      rd_ptr          <= rd_ptr + (AW+1)'(1);
      app_out_valid_o <= 1'b1;
    end else if (app_out_ready_i) begin
      app_out_valid_o <= 1'b0;
    end
  end

  assign out_level_o = committed + (AW+1)'(app_out_valid_o);
  assign out_empty_o = (out_level_o == '0);
  assign out_full_o  = (used == DEPTH_C);

endmodule
